// File: rtl/exe3_pkg.sv
// Shared definitions for the exe3 vote block: default sizing, count type
// and a reference popcount helper.
package exe3_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_THRESHOLD = 2;
    localparam int DEF_CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // Number of set bits in a default-width word.
    function automatic cnt_t popcount(input logic [DEF_WIDTH-1:0] v);
        cnt_t acc;
        acc = '0;
        for (int i = 0; i < DEF_WIDTH; i++) begin
            acc = acc + cnt_t'(v[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/exe3_vote_if.sv
// Status-bus interface for the vote block. The bus has no handshake: the
// master presents a new word every cycle and the slave always samples it;
// out/count are registered copies of the result one cycle later.
interface exe3_vote_if #(
    parameter int WIDTH = exe3_pkg::DEF_WIDTH
);

    logic [WIDTH-1:0]             in;
    logic                         out;
    logic [$clog2(WIDTH+1)-1:0]   count;

    modport master (
        output in,
        input  out,
        input  count
    );

    modport slave (
        input  in,
        output out,
        output count
    );

endinterface

// File: rtl/exe3_popcount.sv
// Purely combinational set-bit counter for a WIDTH-bit word.
module exe3_popcount #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]           word_i,
    output logic [$clog2(WIDTH+1)-1:0] pc_o
);

    localparam int CW = $clog2(WIDTH + 1);

    // Accumulate each input bit; synthesis flattens this into an adder tree.
    always_comb begin
        pc_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc_o = pc_o + CW'(word_i[i]);
        end
    end

endmodule

// File: rtl/exe3_vote.sv
// Registered at-least-THRESHOLD-of-WIDTH vote detector. The popcount of the
// input word is computed combinationally, compared to THRESHOLD, and both
// the count and the flag are registered, giving exactly one cycle latency.
module exe3_vote
    import exe3_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic          clk,
    input  logic          rst,
    exe3_vote_if.slave    vif
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] pc;
    logic [CW-1:0] count_d, count_q;
    logic          out_d, out_q;

    exe3_popcount #(.WIDTH(WIDTH)) u_popcount (
        .word_i (vif.in),
        .pc_o   (pc)
    );

    // A zero threshold is always met; handle it structurally so no
    // degenerate unsigned compare against zero is built.
    generate
        if (THRESHOLD == 0) begin : g_thr_zero
            assign out_d = 1'b1;
        end else begin : g_thr_cmp
            localparam logic [CW:0] THR = (CW+1)'(THRESHOLD);
            assign out_d = ({1'b0, pc} >= THR);
        end
    endgenerate

    assign count_d = pc;

    // Output registers: cleared by synchronous reset, otherwise load this
    // cycle's count and vote result.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            out_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign vif.out   = out_q;
    assign vif.count = count_q;

endmodule

// File: tb/tb_exe3_vote.sv
// Directed bench for exe3_vote: three instances (THRESHOLD 2, 0 and 4) share
// one input word and reset, so each vector checks all three thresholds.
module tb_exe3_vote;

    logic       clk;
    logic       rst;
    logic [3:0] din;

    int n_checks;
    int n_fail;

    logic [5:0] exp_q[$];

    exe3_vote_if #(.WIDTH(4)) bus2 ();
    exe3_vote_if #(.WIDTH(4)) bus0 ();
    exe3_vote_if #(.WIDTH(4)) bus4 ();

    assign bus2.in = din;
    assign bus0.in = din;
    assign bus4.in = din;

    exe3_vote #(.WIDTH(4), .THRESHOLD(2)) dut2 (.clk(clk), .rst(rst), .vif(bus2));
    exe3_vote #(.WIDTH(4), .THRESHOLD(0)) dut0 (.clk(clk), .rst(rst), .vif(bus0));
    exe3_vote #(.WIDTH(4), .THRESHOLD(4)) dut4 (.clk(clk), .rst(rst), .vif(bus4));

    // Clock block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] din;
        logic       out2;
        logic [2:0] cnt;
        logic       out0;
        logic       out4;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every instance's outputs with the expected values.
    task automatic check_all(input string tag, input logic e2, input logic [2:0] ec,
                             input logic e0, input logic e4);
        chk({tag, " out(T2)"},   {7'd0, bus2.out}, {7'd0, e2});
        chk({tag, " count(T2)"}, {5'd0, bus2.count}, {5'd0, ec});
        chk({tag, " out(T0)"},   {7'd0, bus0.out}, {7'd0, e0});
        chk({tag, " count(T0)"}, {5'd0, bus0.count}, {5'd0, ec});
        chk({tag, " out(T4)"},   {7'd0, bus4.out}, {7'd0, e4});
        chk({tag, " count(T4)"}, {5'd0, bus4.count}, {5'd0, ec});
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bench-side model: set-bit count by explicit bit tests.
    function automatic logic [5:0] model(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        if (v[0]) c = c + 3'd1;
        if (v[1]) c = c + 3'd1;
        if (v[2]) c = c + 3'd1;
        if (v[3]) c = c + 3'd1;
        return {(c == 3'd4), 1'b1, (c >= 3'd2), c};
    endfunction

    // Drive one word, push its expectation, and check after the edge.
    task automatic drive_and_score(input logic [3:0] v, input string tag);
        logic [5:0] e;
        din = v;
        exp_q.push_back(model(v));
        tick();
        e = exp_q.pop_front();
        check_all(tag, e[3], e[2:0], e[4], e[5]);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        din      = 4'b1111;

        //            din      out2  cnt   out0  out4
        vecs[0] = '{4'b0000, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1] = '{4'b1010, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[2] = '{4'b1111, 1'b1, 3'd4, 1'b1, 1'b1};
        vecs[3] = '{4'b0101, 1'b1, 3'd2, 1'b1, 1'b0};
        vecs[4] = '{4'b0001, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[5] = '{4'b1000, 1'b0, 3'd1, 1'b1, 1'b0};
        vecs[6] = '{4'b0111, 1'b1, 3'd3, 1'b1, 1'b0};
        vecs[7] = '{4'b1110, 1'b1, 3'd3, 1'b1, 1'b0};

        // Reset held two cycles with all inputs set: outputs stay cleared.
        tick();
        check_all("reset1", 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check_all("reset2", 1'b0, 3'd0, 1'b0, 1'b0);

        // Directed table, one vector per clock.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].din;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].out2, vecs[i].cnt,
                      vecs[i].out0, vecs[i].out4);
        end

        // Threshold edge and one-cycle lag: outputs must not follow in
        // between edges.
        din = 4'b0001;
        tick();
        check_all("thr_below", 1'b0, 3'd1, 1'b1, 1'b0);
        din = 4'b0011;
        #3;
        check_all("lag_hold", 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        check_all("thr_at", 1'b1, 3'd2, 1'b1, 1'b0);
        din = 4'b0000;
        #3;
        check_all("hold_between", 1'b1, 3'd2, 1'b1, 1'b0);

        // Mid-run reset with a steady all-ones input.
        din = 4'b1111;
        tick();
        check_all("pre_rst", 1'b1, 3'd4, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check_all("mid_rst", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_all("post_rst", 1'b1, 3'd4, 1'b1, 1'b1);

        // All 16 words back-to-back against the model.
        for (int v = 0; v < 16; v++) begin
            drive_and_score(4'(v), $sformatf("exh%0d", v));
        end

        // A short run of random words.
        for (int k = 0; k < 24; k++) begin
            drive_and_score(4'($urandom_range(0, 15)), $sformatf("rnd%0d", k));
        end

        chk("queue_empty", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
